// File: rtl/sdr_bus_pkg.sv
// Shared constants and FSM encoding for the SDR bus condition detector.
package sdr_bus_pkg;

    localparam int SYNC_STAGES_DEF  = 2;
    localparam int FILT_CYC_DEF     = 3;
    localparam int BUS_FREE_CYC_DEF = 50;

    // Widths cover the legal parameter ranges (FILT_CYC <= 15, BUS_FREE_CYC <= 1023)
    localparam int FILT_CNT_W = 4;
    localparam int FREE_CNT_W = 10;

    typedef enum logic [1:0] {
        FREE_WAIT = 2'd0,
        FREE      = 2'd1,
        BUSY      = 2'd2
    } bus_state_t;

endpackage

// File: rtl/sdr_sig_filter.sv
// One bus line: SYNC_STAGES flop synchronizer followed by an optional glitch filter
// (compiled in with SDR_BUS_GLITCH_FILTER_EN). Latency SYNC_STAGES (+FILT_CYC in OD); no backpressure.
module sdr_sig_filter
    import sdr_bus_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_CYC    = FILT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic pp_od,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    // Reset to 1: the bus idles pulled up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef SDR_BUS_GLITCH_FILTER_EN
    logic                  level_q;
    logic [FILT_CNT_W-1:0] cnt_q;

    // In push-pull the level tracks the synchronizer so a switch back to
    // open-drain starts from a settled value with a cleared counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else if (pp_od) begin
            level_q <= sync;
            cnt_q   <= '0;
        end else if (sync == level_q) begin
            cnt_q   <= '0;
        end else if (cnt_q == FILT_CNT_W'(FILT_CYC - 1)) begin
            level_q <= sync;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign filt = pp_od ? sync : level_q;
`else
    logic unused_cfg;

    assign unused_cfg = pp_od | (FILT_CYC == 0);
    assign filt       = sync;
`endif

endmodule

// File: rtl/sdr_bus_cond_detector.sv
// SCL/SDA conditioning plus START/repeated-START/STOP detection and bus busy/free tracking.
// Latency raw->pulse SYNC_STAGES+1 (+FILT_CYC in OD with SDR_BUS_GLITCH_FILTER_EN); no backpressure.
module sdr_bus_cond_detector
    import sdr_bus_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int FILT_CYC     = FILT_CYC_DEF,
    parameter int BUS_FREE_CYC = BUS_FREE_CYC_DEF
) (
    input  logic i_sdr_ctrl_clk,
    input  logic i_sdr_ctrl_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    input  logic i_sdr_scl_gen_pp_od,
    output logic o_scl_filt,
    output logic o_sda_filt,
    output logic o_scl_pos_edge,
    output logic o_scl_neg_edge,
    output logic o_start,
    output logic o_rstart,
    output logic o_stop,
    output logic o_bus_busy,
    output logic o_bus_free
);

    bus_state_t            state_q;
    logic [FREE_CNT_W-1:0] free_cnt_q;
    logic                  scl_q;
    logic                  sda_q;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start_cond;
    logic                  stop_cond;
    logic                  lines_high;

    sdr_sig_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYC    (FILT_CYC)
    ) u_scl_filt (
        .clk   (i_sdr_ctrl_clk),
        .rst_n (i_sdr_ctrl_rst_n),
        .raw   (i_scl),
        .pp_od (i_sdr_scl_gen_pp_od),
        .filt  (o_scl_filt)
    );

    sdr_sig_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYC    (FILT_CYC)
    ) u_sda_filt (
        .clk   (i_sdr_ctrl_clk),
        .rst_n (i_sdr_ctrl_rst_n),
        .raw   (i_sda),
        .pp_od (i_sdr_scl_gen_pp_od),
        .filt  (o_sda_filt)
    );

    // SCL must be high on both sides of the SDA transition; a simultaneous
    // SCL change is treated as a clock edge only.
    assign scl_rise   = o_scl_filt & ~scl_q;
    assign scl_fall   = ~o_scl_filt & scl_q;
    assign start_cond = scl_q & o_scl_filt & sda_q & ~o_sda_filt;
    assign stop_cond  = scl_q & o_scl_filt & ~sda_q & o_sda_filt;
    assign lines_high = o_scl_filt & o_sda_filt;

    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            state_q        <= FREE_WAIT;
            free_cnt_q     <= '0;
            scl_q          <= 1'b1;
            sda_q          <= 1'b1;
            o_scl_pos_edge <= 1'b0;
            o_scl_neg_edge <= 1'b0;
            o_start        <= 1'b0;
            o_rstart       <= 1'b0;
            o_stop         <= 1'b0;
            o_bus_busy     <= 1'b0;
            o_bus_free     <= 1'b0;
        end else begin
            scl_q          <= o_scl_filt;
            sda_q          <= o_sda_filt;
            o_scl_pos_edge <= scl_rise;
            o_scl_neg_edge <= scl_fall;
            o_start        <= 1'b0;
            o_rstart       <= 1'b0;
            o_stop         <= 1'b0;

            case (state_q)
                FREE_WAIT: begin
                    if (start_cond) begin
                        state_q    <= BUSY;
                        o_start    <= 1'b1;
                        o_bus_busy <= 1'b1;
                        free_cnt_q <= '0;
                    end else if (lines_high) begin
                        // Counter stops at the threshold, so it never wraps
                        if (free_cnt_q == FREE_CNT_W'(BUS_FREE_CYC - 1)) begin
                            state_q    <= FREE;
                            o_bus_free <= 1'b1;
                        end else begin
                            free_cnt_q <= free_cnt_q + 1'b1;
                        end
                    end else begin
                        free_cnt_q <= '0;
                    end
                end

                FREE: begin
                    if (start_cond) begin
                        state_q    <= BUSY;
                        o_start    <= 1'b1;
                        o_bus_busy <= 1'b1;
                        o_bus_free <= 1'b0;
                        free_cnt_q <= '0;
                    end else if (!lines_high) begin
                        state_q    <= FREE_WAIT;
                        o_bus_free <= 1'b0;
                        free_cnt_q <= '0;
                    end
                end

                BUSY: begin
                    if (start_cond) begin
                        o_rstart <= 1'b1;
                    end else if (stop_cond) begin
                        state_q    <= FREE_WAIT;
                        o_stop     <= 1'b1;
                        o_bus_busy <= 1'b0;
                        free_cnt_q <= '0;
                    end
                end

                default: begin
                    state_q    <= FREE_WAIT;
                    free_cnt_q <= '0;
                    o_bus_busy <= 1'b0;
                    o_bus_free <= 1'b0;
                end
            endcase
        end
    end

endmodule
